// File: rtl/fifo_wr_arbiter.sv
// Two-requester packet arbiter feeding a FIFO write port: a round-robin owner
// holds the write port until its last word is accepted, and the write pointer advances per word.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  input  logic                  w_full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic [1:0]            grant,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a word transfers on a cycle where reqx_valid && reqx_ready are both
  // high; ready depends only on ownership and w_full, never on valid.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic                  winner_q, winner_d;  // 0: req0 won last arbitration
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= 1'b1;  // pretend req1 won last so req0 wins first
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w_en       = 1'b0;
    w_data     = '0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          if (winner_q) begin
            state_d  = OWN0;
            winner_d = 1'b0;
          end else begin
            state_d  = OWN1;
            winner_d = 1'b1;
          end
        end else if (req0_valid) begin
          state_d  = OWN0;
          winner_d = 1'b0;
        end else if (req1_valid) begin
          state_d  = OWN1;
          winner_d = 1'b1;
        end
      end
      OWN0: begin
        req0_ready = !w_full;
        w_en       = req0_valid && !w_full;
        w_data     = req0_data;
        if (w_en && req0_last) state_d = IDLE;
      end
      OWN1: begin
        req1_ready = !w_full;
        w_en       = req1_valid && !w_full;
        w_data     = req1_data;
        if (w_en && req1_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ptr_d       = w_en ? ptr_q + 1'b1 : ptr_q;
  assign w_ptr       = ptr_q;
  assign w_addr      = ptr_q[ADDR_WIDTH-1:0];
  assign grant       = state_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: hand-computed expectations checked with
// immediate assertions after each step.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [DW-1:0] req1_data = '0;
  logic          w_full = 1'b0;
  logic          w_en;
  logic [DW-1:0] w_data;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_ptr;
  logic [1:0]    grant;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .w_full(w_full), .w_en(w_en), .w_data(w_data), .w_addr(w_addr), .w_ptr(w_ptr),
    .grant(grant), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_w_en", w_en, 1'b0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_w_addr", w_addr, 4'd0);
    chk("rst_w_ptr", w_ptr, 5'd0);
    step(); step();
    rst = 1'b0;

    // Single packet on req0
    req0_valid = 1'b1; req0_data = 8'hA1;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_ready0", req0_ready, 1'b0);
    chk("t1_idle_w_en", w_en, 1'b0);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_ready0", req0_ready, 1'b1);
    chk("t1_w_en0", w_en, 1'b1);
    chk("t1_addr0", w_addr, 4'd0);
    chk("t1_data0", w_data, 8'hA1);
    step();
    req0_data = 8'hA2;
    #1;
    chk("t1_addr1", w_addr, 4'd1);
    chk("t1_data1", w_data, 8'hA2);
    step();
    req0_data = 8'hA3; req0_last = 1'b1;
    #1;
    chk("t1_addr2", w_addr, 4'd2);
    chk("t1_data2", w_data, 8'hA3);
    step();
    req0_valid = 1'b0; req0_last = 1'b0;
    #1;
    chk("t1_end_grant", grant, 2'b00);
    chk("t1_end_ptr", w_ptr, 5'd3);

    // Contention after reset
    do_reset();
    chk("t2_ptr_rst", w_ptr, 5'd0);
    req0_valid = 1'b1; req0_data = 8'hB0;
    req1_valid = 1'b1; req1_data = 8'hC0;
    step();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_ready1_off", req1_ready, 1'b0);
    chk("t2_addr0", w_addr, 4'd0);
    chk("t2_data0", w_data, 8'hB0);
    step();
    req0_data = 8'hB1; req0_last = 1'b1;
    #1;
    chk("t2_addr1", w_addr, 4'd1);
    chk("t2_data1", w_data, 8'hB1);
    step();
    req0_valid = 1'b0; req0_last = 1'b0;
    #1;
    chk("t2_idle_grant", grant, 2'b00);
    chk("t2_idle_ready1", req1_ready, 1'b0);
    step();
    chk("t2_grant1", grant, 2'b10);
    chk("t2_addr2", w_addr, 4'd2);
    chk("t2_data2", w_data, 8'hC0);
    step();
    req1_data = 8'hC1; req1_last = 1'b1;
    #1;
    chk("t2_addr3", w_addr, 4'd3);
    chk("t2_data3", w_data, 8'hC1);
    step();
    req1_valid = 1'b0; req1_last = 1'b0;
    #1;
    chk("t2_ptr4", w_ptr, 5'd4);
    req0_valid = 1'b1; req0_data = 8'hB2; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hC2;
    step();
    chk("t2_rr_grant", grant, 2'b01);
    chk("t2_rr_data", w_data, 8'hB2);
    step();
    req0_valid = 1'b0; req0_last = 1'b0; req1_valid = 1'b0;
    #1;
    chk("t2_ptr5", w_ptr, 5'd5);

    // Full stall mid-packet
    req0_valid = 1'b1; req0_data = 8'hD0;
    step();
    chk("t3_addr5", w_addr, 4'd5);
    chk("t3_w_en", w_en, 1'b1);
    step();
    w_full = 1'b1; req0_data = 8'hD1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_stall_ready", req0_ready, 1'b0);
      chk("t3_stall_w_en", w_en, 1'b0);
      chk("t3_stall_ptr", w_ptr, 5'd6);
      chk("t3_stall_grant", grant, 2'b01);
      step();
    end
    w_full = 1'b0; req0_valid = 1'b0;
    #1;
    chk("t3_gap_w_en", w_en, 1'b0);
    chk("t3_gap_grant", grant, 2'b01);
    step();
    req0_valid = 1'b1; req0_last = 1'b1;
    #1;
    chk("t3_resume_w_en", w_en, 1'b1);
    chk("t3_resume_addr", w_addr, 4'd6);
    chk("t3_resume_data", w_data, 8'hD1);
    step();
    req0_valid = 1'b0; req0_last = 1'b0;
    #1;
    chk("t3_ptr7", w_ptr, 5'd7);
    chk("t3_idle", grant, 2'b00);

    // Non-owner isolation
    req0_valid = 1'b1; req0_data = 8'hE0;
    step();
    req1_valid = 1'b1; req1_last = 1'b1; req1_data = 8'hF0;
    #1;
    chk("t4_ready1", req1_ready, 1'b0);
    chk("t4_grant", grant, 2'b01);
    chk("t4_data", w_data, 8'hE0);
    chk("t4_addr", w_addr, 4'd7);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t4_no_w_en", w_en, 1'b0);
    chk("t4_ready1_b", req1_ready, 1'b0);
    chk("t4_ptr8", w_ptr, 5'd8);
    step();
    req0_valid = 1'b1; req0_data = 8'hE1; req0_last = 1'b1;
    req1_valid = 1'b0; req1_last = 1'b0;
    #1;
    chk("t4_addr8", w_addr, 4'd8);
    chk("t4_data8", w_data, 8'hE1);
    step();
    req0_valid = 1'b0; req0_last = 1'b0;
    #1;
    chk("t4_ptr9", w_ptr, 5'd9);

    // Pointer wrap over 33 words
    do_reset();
    req0_valid = 1'b1; req0_data = 8'd0;
    step();
    for (int i = 0; i < 33; i++) begin
      req0_data = 8'(i);
      #1;
      chk("t5_addr", w_addr, 32'(i % 16));
      chk("t5_w_en", w_en, 1'b1);
      step();
      chk("t5_ptr", w_ptr, 32'((i + 1) % 32));
    end
    req0_valid = 1'b0;

    // Reset mid-packet
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h50;
    step();
    chk("t6_own1", grant, 2'b10);
    step(); step();
    chk("t6_ptr2", w_ptr, 5'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_ptr", w_ptr, 5'd0);
    chk("t6_rst_w_en", w_en, 1'b0);
    chk("t6_rst_ready1", req1_ready, 1'b0);
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h60;
    step();
    chk("t6_after_grant", grant, 2'b01);
    chk("t6_after_addr", w_addr, 4'd0);
    chk("t6_after_data", w_data, 8'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
